// File: rtl/microwave_cook_sequencer_if.sv
// rtl/microwave_cook_sequencer_if.sv - front panel / magnetron / display signal bundle for the cook sequencer
interface microwave_cook_sequencer_if;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic       timer_done;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic [1:0] state;

    modport master (
        output startn, stopn, clearn, door_closed, key_valid, key_digit,
        input  mag_on, timer_done, min_tens, min_units, sec_tens, sec_units, state
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, key_valid, key_digit,
        output mag_on, timer_done, min_tens, min_units, sec_tens, sec_units, state
    );
endinterface

// File: rtl/microwave_cook_sequencer.sv
// rtl/microwave_cook_sequencer.sv - mm:ss BCD cook timer with prescaled countdown and magnetron gating
module microwave_cook_sequencer #(
    parameter int TICK_DIV = 100
) (
    input  logic                         clk,
    input  logic                         reset,
    microwave_cook_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COOKING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_e;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [3:0]    mt_q, mt_d, mu_q, mu_d, st_q, st_d, su_q, su_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;

    // Button bits ordered {clear, stop, start}
    logic [2:0]    smp_q, prv_q, prs_q;
    logic [2:0]    btn;

    logic          press_clear, press_stop, press_start;
    logic          time_zero, last_sec, tick, key_ok;
    logic [3:0]    dmt, dmu, dst, dsu;

    assign btn         = {bus.clearn, bus.stopn, bus.startn};
    assign press_clear = prs_q[2];
    assign press_stop  = prs_q[1];
    assign press_start = prs_q[0];

    assign time_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
    assign last_sec  = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);
    assign tick      = (pre_q == PRE_MAX);
    assign key_ok    = bus.key_valid && (bus.key_digit <= 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            smp_q   <= 3'b111;
            prv_q   <= 3'b111;
            prs_q   <= 3'b000;
            state_q <= IDLE;
            mt_q    <= 4'd0;
            mu_q    <= 4'd0;
            st_q    <= 4'd0;
            su_q    <= 4'd0;
            pre_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            smp_q   <= btn;
            prv_q   <= smp_q;
            prs_q   <= prv_q & ~smp_q;
            state_q <= state_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            st_q    <= st_d;
            su_q    <= su_d;
            pre_q   <= pre_d;
            done_q  <= done_d;
        end
    end

    // One-second BCD decrement; seconds above 59 are counted down as entered
    always_comb begin
        dmt = mt_q;
        dmu = mu_q;
        dst = st_q;
        dsu = su_q;
        if (su_q != 4'd0) begin
            dsu = su_q - 4'd1;
        end else if (st_q != 4'd0) begin
            dst = st_q - 4'd1;
            dsu = 4'd9;
        end else begin
            dst = 4'd5;
            dsu = 4'd9;
            if (mu_q != 4'd0) begin
                dmu = mu_q - 4'd1;
            end else begin
                dmt = mt_q - 4'd1;
                dmu = 4'd9;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        st_d    = st_q;
        su_d    = su_q;
        pre_d   = pre_q;
        done_d  = done_q;

        if (press_clear) begin
            state_d = IDLE;
            mt_d    = 4'd0;
            mu_d    = 4'd0;
            st_d    = 4'd0;
            su_d    = 4'd0;
            pre_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_stop) begin
                        state_d = IDLE;
                    end else if (press_start && bus.door_closed && !time_zero) begin
                        state_d = COOKING;
                        pre_d   = '0;
                    end else if (key_ok) begin
                        mt_d = mu_q;
                        mu_d = st_q;
                        st_d = su_q;
                        su_d = bus.key_digit;
                    end
                end
                COOKING: begin
                    // Door and stop preempt the tick so the prescaler holds
                    if (press_stop || !bus.door_closed) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        pre_d = '0;
                        mt_d  = dmt;
                        mu_d  = dmu;
                        st_d  = dst;
                        su_d  = dsu;
                        if (last_sec) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (press_stop) begin
                        state_d = IDLE;
                        mt_d    = 4'd0;
                        mu_d    = 4'd0;
                        st_d    = 4'd0;
                        su_d    = 4'd0;
                    end else if (press_start && bus.door_closed) begin
                        state_d = COOKING;
                    end
                end
                DONE: begin
                    if (press_stop || !bus.door_closed) begin
                        state_d = IDLE;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Door gate stays combinational so the magnetron drops without waiting for a clock
    assign bus.mag_on     = (state_q == COOKING) && bus.door_closed;
    assign bus.timer_done = done_q;
    assign bus.min_tens   = mt_q;
    assign bus.min_units  = mu_q;
    assign bus.sec_tens   = st_q;
    assign bus.sec_units  = su_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// tb/tb_microwave_cook_sequencer.sv - directed and random bench for the cook sequencer with a behavioural model
module tb_microwave_cook_sequencer;
    localparam int T = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    microwave_cook_sequencer_if bus();

    microwave_cook_sequencer #(.TICK_DIV(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    // Model: state code, minutes and seconds as integers, prescaler count
    int       m_st = 0;
    int       m_min = 0;
    int       m_sec = 0;
    int       m_pre = 0;
    bit       m_done = 1'b0;
    bit [2:0] hs = 3'b111;
    bit [2:0] hp = 3'b111;
    bit [2:0] hc = 3'b111;

    task automatic model_update();
        bit pst, psp, pcl, dc;
        int n;
        pst = hs[2] & ~hs[1];
        psp = hp[2] & ~hp[1];
        pcl = hc[2] & ~hc[1];
        dc  = bus.door_closed;
        if (reset) begin
            m_st = 0; m_min = 0; m_sec = 0; m_pre = 0; m_done = 1'b0;
            hs = 3'b111; hp = 3'b111; hc = 3'b111;
            return;
        end
        hs = {hs[1:0], bus.startn};
        hp = {hp[1:0], bus.stopn};
        hc = {hc[1:0], bus.clearn};
        if (pcl) begin
            m_st = 0; m_min = 0; m_sec = 0; m_pre = 0; m_done = 1'b0;
        end else if (m_st == 0) begin
            if (psp) begin
            end else if (pst && dc && (m_min != 0 || m_sec != 0)) begin
                m_st = 1; m_pre = 0;
            end else if (bus.key_valid && bus.key_digit <= 9) begin
                n = ((m_min * 100 + m_sec) * 10 + int'(bus.key_digit)) % 10000;
                m_min = n / 100;
                m_sec = n % 100;
            end
        end else if (m_st == 1) begin
            if (psp || !dc) begin
                m_st = 2;
            end else if (m_pre == T - 1) begin
                m_pre = 0;
                if (m_sec > 0) m_sec = m_sec - 1;
                else begin m_min = m_min - 1; m_sec = 59; end
                if (m_min == 0 && m_sec == 0) begin m_st = 3; m_done = 1'b1; end
            end else begin
                m_pre = m_pre + 1;
            end
        end else if (m_st == 2) begin
            if (psp) begin m_st = 0; m_min = 0; m_sec = 0; end
            else if (pst && dc) m_st = 1;
        end else begin
            if (psp || !dc) begin m_st = 0; m_done = 1'b0; end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [19:0] obs, exp;
        logic [3:0] e_mt, e_mu, e_st, e_su;
        e_mt = 4'(m_min / 10);
        e_mu = 4'(m_min % 10);
        e_st = 4'(m_sec / 10);
        e_su = 4'(m_sec % 10);
        obs = {bus.state, bus.mag_on, bus.timer_done, bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
        exp = {2'(m_st), (m_st == 1) && bus.door_closed, m_done, e_mt, e_mu, e_st, e_su};
        chk("model", 32'(obs), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // which: bit0 start, bit1 stop, bit2 clear
    task automatic press(input int which);
        if (which[0]) bus.startn = 1'b0;
        if (which[1]) bus.stopn  = 1'b0;
        if (which[2]) bus.clearn = 1'b0;
        step();
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        step();
        step();
    endtask

    task automatic key(input logic [3:0] d);
        bus.key_valid = 1'b1;
        bus.key_digit = d;
        step();
        bus.key_valid = 1'b0;
        bus.key_digit = 4'd0;
    endtask

    function automatic logic [15:0] digits();
        return {bus.min_tens, bus.min_units, bus.sec_tens, bus.sec_units};
    endfunction

    initial begin
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1; bus.key_valid = 1'b0; bus.key_digit = 4'd0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset_state", 32'(bus.state), 32'd0);
        chk("reset_mag", 32'(bus.mag_on), 32'd0);
        chk("reset_done", 32'(bus.timer_done), 32'd0);
        chk("reset_digits", 32'(digits()), 32'h0000);

        key(4'd1); key(4'd3); key(4'd0);
        chk("key_0130", 32'(digits()), 32'h0130);
        press(1);
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_mag", 32'(bus.mag_on), 32'd1);
        steps(90 * T - 1);
        chk("pre_final", 32'(digits()), 32'h0001);
        step();
        chk("done_state", 32'(bus.state), 32'd3);
        chk("done_flag", 32'(bus.timer_done), 32'd1);
        chk("done_mag", 32'(bus.mag_on), 32'd0);
        chk("done_digits", 32'(digits()), 32'h0000);
        press(1);
        chk("done_start_ignored", 32'(bus.state), 32'd3);
        press(4);
        chk("done_clear", 32'(bus.state), 32'd0);

        key(4'd1); key(4'd0);
        press(1);
        steps(3 * T);
        chk("three_ticks", 32'(digits()), 32'h0007);
        bus.door_closed = 1'b0;
        #1;
        chk("door_mag_comb", 32'(bus.mag_on), 32'd0);
        step();
        chk("door_paused", 32'(bus.state), 32'd2);
        chk("door_digits", 32'(digits()), 32'h0007);
        bus.door_closed = 1'b1;
        press(1);
        chk("resume_state", 32'(bus.state), 32'd1);
        steps(7 * T - 1);
        chk("resume_last", 32'(digits()), 32'h0001);
        step();
        chk("resume_done", 32'(bus.state), 32'd3);
        bus.door_closed = 1'b0;
        step();
        chk("done_door_idle", 32'(bus.state), 32'd0);
        chk("done_door_flag", 32'(bus.timer_done), 32'd0);
        bus.door_closed = 1'b1;

        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        press(1);
        steps(T);
        chk("wrap_0959", 32'(digits()), 32'h0959);
        press(4);
        chk("clear_digits", 32'(digits()), 32'h0000);
        key(4'd7); key(4'd5);
        press(1);
        steps(T);
        chk("sec75_74", 32'(digits()), 32'h0074);
        steps(74 * T);
        chk("sec75_done", 32'(bus.state), 32'd3);
        press(4);

        bus.door_closed = 1'b0;
        key(4'd5);
        press(1);
        chk("start_door_open", 32'(bus.state), 32'd0);
        chk("start_door_mag", 32'(bus.mag_on), 32'd0);
        bus.door_closed = 1'b1;
        press(4);
        press(1);
        chk("start_zero", 32'(bus.state), 32'd0);
        key(4'd3); key(4'd12);
        chk("key_12_ignored", 32'(digits()), 32'h0003);
        press(4);

        key(4'd2); key(4'd0);
        press(1);
        press(7);
        chk("all_three_state", 32'(bus.state), 32'd0);
        chk("all_three_digits", 32'(digits()), 32'h0000);
        key(4'd2); key(4'd0);
        press(1);
        press(2);
        chk("stop1_paused", 32'(bus.state), 32'd2);
        press(2);
        chk("stop2_idle", 32'(bus.state), 32'd0);
        chk("stop2_digits", 32'(digits()), 32'h0000);

        key(4'd4); key(4'd2);
        press(1);
        chk("cook_0042", 32'(digits()), 32'h0042);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_state", 32'(bus.state), 32'd0);
        chk("midreset_digits", 32'(digits()), 32'h0000);
        chk("midreset_mag", 32'(bus.mag_on), 32'd0);
        chk("midreset_done", 32'(bus.timer_done), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)  bus.startn = ~bus.startn;
            if ($urandom_range(0, 11) == 0) bus.stopn  = ~bus.stopn;
            if ($urandom_range(0, 39) == 0) bus.clearn = ~bus.clearn;
            if ($urandom_range(0, 49) == 0) bus.door_closed = ~bus.door_closed;
            bus.key_valid = ($urandom_range(0, 5) == 0);
            bus.key_digit = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
